dot_i8_stream: RTL

Streaming, pipelined signed-integer dot-product engine for MX block arithmetic. It accepts `lanes` element pairs per beat over a valid/ready handshake and accumulates beats until a `last`-tagged beat. It then emits one full-precision result, so one block of length `lanes × beats` is reduced without a `k`-wide datapath. It succeeds the single-shot registered dot unit: parametrised lane count and accumulation depth, backpressure, and multi-beat accumulation.

---
 rtl/mx_pkg.sv | 14 +
 rtl/dot_i8_stream_if.sv | 29 ++
 rtl/dot_i8_lanes.sv | 22 ++
 rtl/dot_i8_stream.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mx_pkg.sv
// Shared width constants and the accumulator-width derivation for the MX dot-product blocks.
// The same function sizes the engine, its interface and the bench, so all of them agree on o_dp.
package mx_pkg;

    localparam int MX_BIT_WIDTH = 8;
    localparam int MX_LANES     = 8;
    localparam int MX_ACC_BEATS = 4;

    // Full-precision product width plus enough growth bits for lanes*beats terms.
    function automatic int acc_width_f(input int bit_width, input int lanes, input int acc_beats);
        return 2 * bit_width + $clog2(lanes * acc_beats);
    endfunction

endpackage

// File: rtl/dot_i8_stream_if.sv
// Beat/result handshake bundle for dot_i8_stream: operand lanes in, one accumulated result out.
interface dot_i8_stream_if
    import mx_pkg::*;
#(
    parameter int bit_width = MX_BIT_WIDTH,
    parameter int lanes     = MX_LANES,
    parameter int acc_beats = MX_ACC_BEATS,
    parameter int acc_width = acc_width_f(bit_width, lanes, acc_beats)
);
    logic                        i_valid;
    logic                        o_ready;
    logic signed [bit_width-1:0] i_op0 [lanes];
    logic signed [bit_width-1:0] i_op1 [lanes];
    logic                        i_last;
    logic                        o_valid;
    logic                        i_ready;
    logic signed [acc_width-1:0] o_dp;
    logic                        o_ovf;

    modport slave (
        input  i_valid, i_op0, i_op1, i_last, i_ready,
        output o_ready, o_valid, o_dp, o_ovf
    );

    modport master (
        output i_valid, i_op0, i_op1, i_last, i_ready,
        input  o_ready, o_valid, o_dp, o_ovf
    );
endinterface

// File: rtl/dot_i8_lanes.sv
// Combinational lane multiply and reduction: sum of op0[i]*op1[i] at accumulator width.
module dot_i8_lanes
    import mx_pkg::*;
#(
    parameter int bit_width = MX_BIT_WIDTH,
    parameter int lanes     = MX_LANES,
    parameter int acc_width = acc_width_f(MX_BIT_WIDTH, MX_LANES, MX_ACC_BEATS)
) (
    input  logic signed [bit_width-1:0] op0 [lanes],
    input  logic signed [bit_width-1:0] op1 [lanes],
    output logic signed [acc_width-1:0] partial
);

    // Sign-extend each operand before multiplying so every product is exact, then widen and sum.
    always_comb begin
        partial = '0;
        for (int i = 0; i < lanes; i++) begin
            partial = partial + acc_width'((2*bit_width)'(op0[i]) * (2*bit_width)'(op1[i]));
        end
    end

endmodule

// File: rtl/dot_i8_stream.sv
// Streaming signed dot-product engine: S1 operand register, S2 lane partial sum, S3 accumulator/result.
// Optional saturation is enabled with the macro DOT_I8_STREAM_SAT_EN; without it the accumulator wraps.
module dot_i8_stream
    import mx_pkg::*;
#(
    parameter int bit_width = MX_BIT_WIDTH,
    parameter int lanes     = MX_LANES,
    parameter int acc_beats = MX_ACC_BEATS,
    parameter int acc_width = acc_width_f(bit_width, lanes, acc_beats)
) (
    input logic          i_clk,
    input logic          i_rst_n,
    dot_i8_stream_if.slave bus
);

    logic                        en;
    logic                        s1_valid;
    logic                        s1_last;
    logic signed [bit_width-1:0] s1_op0 [lanes];
    logic signed [bit_width-1:0] s1_op1 [lanes];
    logic signed [acc_width-1:0] partial;
    logic signed [acc_width-1:0] s2_partial;
    logic                        s2_valid;
    logic                        s2_last;
    logic signed [acc_width-1:0] acc;
    logic signed [acc_width-1:0] base;
    logic signed [acc_width-1:0] sum;
    logic signed [acc_width-1:0] dp;
    logic                        first;
    logic                        res_valid;

    // The whole pipeline freezes only while a finished result is waiting on the consumer.
    assign en          = !(res_valid && !bus.i_ready);
    assign bus.o_ready = en;
    assign bus.o_valid = res_valid;
    assign bus.o_dp    = dp;
    assign base        = first ? '0 : acc;

    // S1: capture the accepted beat; a bubble is recorded when no beat is offered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int i = 0; i < lanes; i++) begin
                s1_op0[i] <= '0;
                s1_op1[i] <= '0;
            end
        end else if (en) begin
            s1_valid <= bus.i_valid;
            s1_last  <= bus.i_last;
            s1_op0   <= bus.i_op0;
            s1_op1   <= bus.i_op1;
        end
    end

    dot_i8_lanes #(
        .bit_width (bit_width),
        .lanes     (lanes),
        .acc_width (acc_width)
    ) u_lanes (
        .op0     (s1_op0),
        .op1     (s1_op1),
        .partial (partial)
    );

    // S2: register the lane partial sum with its beat tags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s2_partial <= '0;
        end else if (en) begin
            s2_valid   <= s1_valid;
            s2_last    <= s1_last;
            s2_partial <= partial;
        end
    end

`ifdef DOT_I8_STREAM_SAT_EN
    localparam logic signed [acc_width-1:0] SAT_MAX = {1'b0, {(acc_width-1){1'b1}}};
    localparam logic signed [acc_width-1:0] SAT_MIN = {1'b1, {(acc_width-1){1'b0}}};

    logic signed [acc_width:0] wide;
    logic                      sat_now;
    logic                      sat_sticky;
    logic                      ovf_next;
    logic                      ovf_q;

    // One extra bit exposes signed overflow; once a dot product has clamped it stays at the rail.
    always_comb begin
        wide     = {base[acc_width-1], base} + {s2_partial[acc_width-1], s2_partial};
        sat_now  = wide[acc_width] != wide[acc_width-1];
        ovf_next = (!first && sat_sticky) || sat_now;
        if (!first && sat_sticky) begin
            sum = acc;
        end else if (sat_now) begin
            sum = wide[acc_width] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = wide[acc_width-1:0];
        end
    end

    // Track overflow over the current dot product and publish it alongside the result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_sticky <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (en && s2_valid) begin
            if (s2_last) begin
                ovf_q      <= ovf_next;
                sat_sticky <= 1'b0;
            end else begin
                sat_sticky <= ovf_next;
            end
        end
    end

    assign bus.o_ovf = ovf_q;
`else
    // Plain modular accumulation.
    always_comb begin
        sum = base + s2_partial;
    end

    assign bus.o_ovf = 1'b0;
`endif

    // S3: accumulate non-last beats, load the result on the last beat, drop o_valid once consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc       <= '0;
            dp        <= '0;
            res_valid <= 1'b0;
            first     <= 1'b1;
        end else if (en) begin
            if (s2_valid && s2_last) begin
                dp        <= sum;
                res_valid <= 1'b1;
                first     <= 1'b1;
            end else begin
                res_valid <= 1'b0;
                if (s2_valid) begin
                    acc   <= sum;
                    first <= 1'b0;
                end
            end
        end
    end

endmodule
